// File: rtl/wb_bram_ctrl_pkg.sv
// Shared types and default parameters for the Wishbone-to-BRAM bridge.
package wb_bram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StAck   = 2'd3
  } state_e;

  localparam logic [31:0] DefBaseAddr = 32'h3800_0000;
  localparam logic [31:0] DefAddrMask = 32'hFFC0_0000;
  localparam int unsigned DefDelay    = 10;

endpackage

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave bridging single accesses onto a synchronous BRAM port
// with a fixed request-to-ack latency of DELAY cycles.
module wb_bram_ctrl
  import wb_bram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefBaseAddr,
  parameter logic [31:0] ADDR_MASK = DefAddrMask,
  parameter int unsigned DELAY     = DefDelay
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_di,
  output logic [31:0] bram_a,
  input  logic [31:0] bram_do
);

  // WAIT lasts DELAY-2 cycles; the counter runs from DELAY-3 down to 0.
  localparam logic [7:0] DelayLoad = 8'(DELAY - 3);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hit;
  logic        issue;
  logic        ack;

  assign hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          state_d = StIssue;
          adr_d   = wbs_adr_i;
          dat_d   = wbs_dat_i;
          sel_d   = wbs_sel_i;
          we_d    = wbs_we_i;
        end
      end
      StIssue: begin
        cnt_d   = DelayLoad;
        state_d = wbs_cyc_i ? StWait : StIdle;
      end
      StWait: begin
        // BRAM data is only valid in the first WAIT cycle.
        if (cnt_q == DelayLoad && !we_q) begin
          rdata_d = bram_do;
        end
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  assign issue     = (state_q == StIssue);
  assign ack       = (state_q == StAck);
  assign bram_en   = issue;
  assign bram_a    = issue ? ((adr_q & ~ADDR_MASK) >> 2) : '0;
  assign bram_we   = (issue && we_q) ? sel_q : '0;
  assign bram_di   = issue ? dat_q : '0;
  assign wbs_ack_o = ack;
  assign wbs_dat_o = (ack && !we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Self-checking bench for wb_bram_ctrl: vector table, read-data scoreboard,
// and hand sequences for miss, cyc abort and mid-transaction reset.
module tb_wb_bram_ctrl;

  localparam int DELAY = 10;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_di;
  logic [31:0] bram_a;
  logic [31:0] bram_do = '0;

  wb_bram_ctrl #(
    .BASE_ADDR(32'h3800_0000),
    .ADDR_MASK(32'hFFC0_0000),
    .DELAY    (DELAY)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .bram_en  (bram_en),
    .bram_we  (bram_we),
    .bram_di  (bram_di),
    .bram_a   (bram_a),
    .bram_do  (bram_do)
  );

  always #5 CLK = ~CLK;

  // BRAM model: registered read, byte-lane writes, zero output when idle.
  logic [31:0] mem [256] = '{default: '0};
  always @(posedge CLK) begin
    if (bram_en) begin
      bram_do <= mem[bram_a[7:0]];
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_a[7:0]][8*b +: 8] <= bram_di[8*b +: 8];
      end
    end else begin
      bram_do <= '0;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_a;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] model [256] = '{default: '0};
  logic [31:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic release_bus();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = '0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model[a[7:0]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
  endtask

  // Called mid-cycle T; returns mid-cycle T+DELAY+1 with the bus idle.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp_a);
    logic [31:0] exp_rd;
    if (we) begin
      model_write(exp_a, dat, sel);
      exp_rd = '0;
    end else begin
      exp_rd = model[exp_a[7:0]];
    end
    exp_q.push_back(exp_rd);
    drive(we, adr, dat, sel);
    for (int k = 1; k <= DELAY + 1; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        check("issue_en", 32'(bram_en), 32'd1);
        check("issue_a", bram_a, exp_a);
        check("issue_we", 32'(bram_we), 32'(we ? sel : 4'h0));
        check("issue_di", bram_di, dat);
      end else begin
        check("en_outside_issue", 32'(bram_en), 32'd0);
      end
      check("ack_timing", 32'(wbs_ack_o), 32'(k == DELAY));
      if (k == DELAY && wbs_ack_o) begin
        check("ack_rdata", wbs_dat_o, exp_q.pop_front());
      end else if (k != DELAY) begin
        check("dat_o_idle", wbs_dat_o, 32'd0);
      end
      // Changes while busy must not disturb the latched request.
      if (k == 2) begin
        wbs_stb_i = 1'b0;
        wbs_adr_i = 32'h3000_0004;
        wbs_dat_i = '1;
      end
      if (k == DELAY) release_bus();
    end
  endtask

  initial begin
    int seen;
    vecs[0] = '{we: 1'b1, adr: 32'h3800_0010, dat: 32'hDEAD_BEEF, sel: 4'hF, exp_a: 32'd4};
    vecs[1] = '{we: 1'b0, adr: 32'h3800_0010, dat: 32'h0,         sel: 4'hF, exp_a: 32'd4};
    vecs[2] = '{we: 1'b1, adr: 32'h3800_0010, dat: 32'h0000_AB00, sel: 4'h2, exp_a: 32'd4};
    vecs[3] = '{we: 1'b0, adr: 32'h3800_0010, dat: 32'h0,         sel: 4'hF, exp_a: 32'd4};
    vecs[4] = '{we: 1'b1, adr: 32'h383F_FFFF, dat: 32'h1234_5678, sel: 4'hF,
                exp_a: 32'h000F_FFFF};
    vecs[5] = '{we: 1'b0, adr: 32'h383F_FFFC, dat: 32'h0,         sel: 4'h0,
                exp_a: 32'h000F_FFFF};
    vecs[6] = '{we: 1'b1, adr: 32'h3800_0010, dat: 32'hFFFF_FFFF, sel: 4'h0, exp_a: 32'd4};
    vecs[7] = '{we: 1'b0, adr: 32'h3800_0013, dat: 32'h0,         sel: 4'hF, exp_a: 32'd4};

    // Outputs during reset, before any clock edge.
    #2;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat_o", wbs_dat_o, 32'd0);
    check("rst_en", 32'(bram_en), 32'd0);
    check("rst_a", bram_a, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    foreach (vecs[i]) do_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp_a);

    // Out-of-window request is ignored.
    drive(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bram_en || wbs_ack_o) seen++;
    end
    check("miss_ignored", 32'(seen), 32'd0);
    release_bus();
    @(negedge CLK);

    // cyc dropped at T+5 of a read: no ack, idle at T+6, next hit at T+7.
    drive(1'b0, 32'h3800_0010, 32'h0, 4'hF);
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      check("abort_no_ack", 32'(wbs_ack_o), 32'd0);
      if (k == 5) release_bus();
      if (k == 6) check("abort_idle", 32'(dut.state_q), 32'd0);
    end
    do_txn(1'b0, 32'h3800_0010, 32'h0, 4'hF, 32'd4);

    // Reset at T+4 of a write: outputs clear immediately, write stays committed.
    model_write(32'd16, 32'hCAFE_F00D, 4'hF);
    drive(1'b1, 32'h3800_0040, 32'hCAFE_F00D, 4'hF);
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      if (k == 1) check("rst_txn_issue", 32'(bram_en), 32'd1);
      check("rst_txn_no_ack", 32'(wbs_ack_o), 32'd0);
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_en", 32'(bram_en), 32'd0);
    check("midrst_we", 32'(bram_we), 32'd0);
    check("midrst_ack", 32'(wbs_ack_o), 32'd0);
    check("midrst_dat_o", wbs_dat_o, 32'd0);
    release_bus();
    seen = 0;
    repeat (2) begin
      @(negedge CLK);
      if (wbs_ack_o) seen++;
    end
    check("midrst_no_ack", 32'(seen), 32'd0);
    // Hit presented together with reset release is taken on the first edge.
    RST = 1'b0;
    do_txn(1'b0, 32'h3800_0040, 32'h0, 4'hF, 32'd16);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
